exwb_arbiter: RTL and testbench

- Writeback stage directly downstream of the execute cluster.
- Captures results from the four execution units (ALU, forwarder, jump, branch) into per-unit FIFOs.
- Arbitrates round-robin onto a single registered result bus consumed by the ROB and reservation-station snoopers.
- Drives per-unit stall back to the units so no result is lost.

---
 rtl/exwb_pkg.sv | 33 +++
 rtl/exwb_fifo.sv | 58 +++++
 rtl/exwb_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_exwb_arbiter.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/exwb_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | exwb_pkg : shared types and constants for the writeback arbiter     |
// | Revision : 1.0                                                      |
// +--------------------------------------------------------------------+
package exwb_pkg;

  localparam int WB_DATA_W = 32;
  localparam int WB_TAG_W  = 5;
  localparam int NUM_UNITS = 4;

  localparam logic [1:0] ALU    = 2'd0;
  localparam logic [1:0] FWD    = 2'd1;
  localparam logic [1:0] JUMP   = 2'd2;
  localparam logic [1:0] BRANCH = 2'd3;

  localparam logic [WB_TAG_W-1:0] TAG_INVALID = '1;

  typedef struct packed {
    logic [WB_TAG_W-1:0]  target;
    logic [WB_DATA_W-1:0] value;
    logic [WB_DATA_W-1:0] next_pc;
    logic                 taken;
    logic [1:0]           unit;
  } wb_entry_t;

  // Round-robin successor of a unit index (wraps naturally at 2 bits).
  function automatic logic [1:0] next_unit(input logic [1:0] u);
    return u + 2'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/exwb_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | exwb_fifo : single-clock FIFO of writeback entries with flush       |
// | Revision  : 1.0                                                     |
// +--------------------------------------------------------------------+
module exwb_fifo
  import exwb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  wb_entry_t              din,
  output wb_entry_t              dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);

  wb_entry_t   r_mem [DEPTH];
  logic [AW:0] r_wptr;
  logic [AW:0] r_rptr;
  logic        w_wr;
  logic        w_rd;

  // A full FIFO may still take a write when the head leaves in the same cycle.
  assign w_wr = push & (~full | pop) & ~flush;
  assign w_rd = pop & ~empty & ~flush;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else if (flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + 1'b1;
      if (w_rd) r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr[AW-1:0]] <= din;
  end

  assign dout  = r_mem[r_rptr[AW-1:0]];
  assign empty = (r_wptr == r_rptr);
  assign full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign count = r_wptr - r_rptr;

endmodule
`default_nettype wire

// File: rtl/exwb_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | exwb_arbiter : four-unit writeback buffer with round-robin result   |
// |                bus; EXWB_PERF_CNT_EN adds per-unit conflict counters |
// | Revision     : 1.0                                                  |
// +--------------------------------------------------------------------+
module exwb_arbiter
  import exwb_pkg::*;
#(
  parameter int DATA_W     = WB_DATA_W,
  parameter int TAG_W      = WB_TAG_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic [TAG_W-1:0]  alu_target,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [TAG_W-1:0]  fwd_target,
  input  logic [DATA_W-1:0] fwd_result,
  input  logic [TAG_W-1:0]  jmp_target,
  input  logic [DATA_W-1:0] jmp_ori_pc,
  input  logic [DATA_W-1:0] jmp_next_pc,
  input  logic [TAG_W-1:0]  br_target,
  input  logic [DATA_W-1:0] br_next_pc,
  input  logic              br_cmp_res,
  output logic [3:0]        stall,
  output logic [TAG_W-1:0]  wb_target,
  output logic [DATA_W-1:0] wb_value,
  output logic [DATA_W-1:0] wb_next_pc,
  output logic              wb_taken,
  output logic [1:0]        wb_unit,
`ifdef EXWB_PERF_CNT_EN
  output logic [3:0][15:0]  perf_conflict,
`endif
  output logic              overflow_err
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  wb_entry_t [3:0]            w_in;
  wb_entry_t [3:0]            w_head;
  logic      [3:0]            w_push;
  logic      [3:0]            w_full;
  logic      [3:0]            w_empty;
  logic      [3:0]            w_req;
  logic      [3:0]            w_wr;
  logic      [3:0]            w_rd;
  logic      [3:0]            w_gnt_oh;
  logic      [3:0][CNT_W-1:0] w_cnt;
  logic      [3:0][CNT_W-1:0] w_cnt_nxt;
  logic      [1:0]            w_idx;
  logic      [1:0]            w_win;
  logic                       w_gnt_vld;
  logic                       w_drop;
  wb_entry_t                  w_sel;

  logic      [1:0]            r_rr;
  logic      [3:0]            r_stall;
  logic                       r_ovf;
  wb_entry_t                  r_wb;

  always_comb begin
    w_in = '0;
    w_in[ALU].target     = alu_target;
    w_in[ALU].value      = alu_result;
    w_in[ALU].unit       = ALU;
    w_in[FWD].target     = fwd_target;
    w_in[FWD].value      = fwd_result;
    w_in[FWD].unit       = FWD;
    w_in[JUMP].target    = jmp_target;
    w_in[JUMP].value     = jmp_ori_pc;
    w_in[JUMP].next_pc   = jmp_next_pc;
    w_in[JUMP].taken     = 1'b1;
    w_in[JUMP].unit      = JUMP;
    w_in[BRANCH].target  = br_target;
    w_in[BRANCH].next_pc = br_next_pc;
    w_in[BRANCH].taken   = br_cmp_res;
    w_in[BRANCH].unit    = BRANCH;
  end

  generate
    for (genvar u = 0; u < NUM_UNITS; u++) begin : g_fifo
      assign w_push[u] = (w_in[u].target != TAG_INVALID);

      exwb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .push  (w_wr[u]),
        .pop   (w_rd[u]),
        .din   (w_in[u]),
        .dout  (w_head[u]),
        .count (w_cnt[u]),
        .full  (w_full[u]),
        .empty (w_empty[u])
      );
    end
  endgenerate

  // An arriving result counts as present so an idle arbiter forwards it directly.
  assign w_req = ~w_empty | w_push;

  always_comb begin
    w_gnt_vld = 1'b0;
    w_win     = r_rr;
    w_idx     = r_rr;
    for (int i = 0; i < NUM_UNITS; i++) begin
      w_idx = r_rr + 2'(i);
      if (!w_gnt_vld && w_req[w_idx]) begin
        w_gnt_vld = 1'b1;
        w_win     = w_idx;
      end
    end
    if (flush) w_gnt_vld = 1'b0;
  end

  assign w_gnt_oh = w_gnt_vld ? (4'b0001 << w_win) : 4'b0000;
  assign w_sel    = w_empty[w_win] ? w_in[w_win] : w_head[w_win];

  always_comb begin
    w_wr      = '0;
    w_rd      = '0;
    w_cnt_nxt = w_cnt;
    for (int u = 0; u < NUM_UNITS; u++) begin
      // A granted push into an empty FIFO bypasses storage entirely.
      w_wr[u] = w_push[u] & ~flush & ~(w_empty[u] & w_gnt_oh[u])
              & (~w_full[u] | w_gnt_oh[u]);
      w_rd[u] = w_gnt_oh[u] & ~w_empty[u];
      w_cnt_nxt[u] = w_cnt[u] + CNT_W'(w_wr[u]) - CNT_W'(w_rd[u]);
    end
  end

  assign w_drop = ~flush & |(w_push & w_full & ~w_gnt_oh);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rr    <= ALU;
      r_stall <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (flush)          r_rr <= ALU;
      else if (w_gnt_vld) r_rr <= next_unit(w_win);
      for (int u = 0; u < NUM_UNITS; u++) begin
        r_stall[u] <= ~flush && (w_cnt_nxt[u] >= CNT_W'(FIFO_DEPTH - 1));
      end
      if (w_drop) r_ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wb        <= '0;
      r_wb.target <= TAG_INVALID;
    end else if (w_gnt_vld) begin
      r_wb <= w_sel;
    end else begin
      r_wb.target <= TAG_INVALID;
    end
  end

  assign stall        = r_stall;
  assign overflow_err = r_ovf;
  assign wb_target    = r_wb.target;
  assign wb_value     = r_wb.value;
  assign wb_next_pc   = r_wb.next_pc;
  assign wb_taken     = r_wb.taken;
  assign wb_unit      = r_wb.unit;

`ifdef EXWB_PERF_CNT_EN
  logic [3:0][15:0] r_perf;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_perf <= '0;
    end else begin
      for (int u = 0; u < NUM_UNITS; u++) begin
        if (!w_empty[u] && !w_gnt_oh[u] && (r_perf[u] != 16'hFFFF))
          r_perf[u] <= r_perf[u] + 16'd1;
      end
    end
  end

  assign perf_conflict = r_perf;
`endif

endmodule
`default_nettype wire

// File: tb/tb_exwb_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_exwb_arbiter : queue-model bench for the writeback arbiter       |
// | Revision        : 1.0                                               |
// +--------------------------------------------------------------------+
module tb_exwb_arbiter;

  localparam int         DEPTH = 4;
  localparam logic [4:0] INV   = 5'h1f;

  typedef struct packed {
    logic [4:0]  target;
    logic [31:0] value;
    logic [31:0] next_pc;
    logic        taken;
    logic [1:0]  unit;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic [4:0]  alu_target = INV, fwd_target = INV, jmp_target = INV, br_target = INV;
  logic [31:0] alu_result = '0, fwd_result = '0, jmp_ori_pc = '0, jmp_next_pc = '0, br_next_pc = '0;
  logic        br_cmp_res = 1'b0;
  logic [3:0]  stall;
  logic [4:0]  wb_target;
  logic [31:0] wb_value, wb_next_pc;
  logic        wb_taken;
  logic [1:0]  wb_unit;
  logic        overflow_err;

  int checks = 0;
  int failures = 0;
  int dut_alu_bc = 0;
  int dut_bc = 0;

  exwb_arbiter dut (
    .clk(clk), .rst(rst), .flush(flush),
    .alu_target(alu_target), .alu_result(alu_result),
    .fwd_target(fwd_target), .fwd_result(fwd_result),
    .jmp_target(jmp_target), .jmp_ori_pc(jmp_ori_pc), .jmp_next_pc(jmp_next_pc),
    .br_target(br_target), .br_next_pc(br_next_pc), .br_cmp_res(br_cmp_res),
    .stall(stall), .wb_target(wb_target), .wb_value(wb_value),
    .wb_next_pc(wb_next_pc), .wb_taken(wb_taken), .wb_unit(wb_unit),
    .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 30) $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one queue per unit, round-robin scan, entries built from unit rules.
  ent_t       mq [4][$];
  int         m_rr;
  ent_t       m_wb;
  logic [3:0] m_stall;
  logic       m_ovf;

  always @(posedge clk or negedge rst) begin : model
    ent_t in_e [4];
    bit   pushv [4];
    bit   found;
    int   win;
    int   u;
    if (!rst) begin
      for (int k = 0; k < 4; k++) mq[k].delete();
      m_rr = 0; m_wb = '0; m_wb.target = INV; m_stall = '0; m_ovf = 1'b0;
    end else begin
      in_e[0] = '{target: alu_target, value: alu_result, next_pc: 32'd0, taken: 1'b0, unit: 2'd0};
      in_e[1] = '{target: fwd_target, value: fwd_result, next_pc: 32'd0, taken: 1'b0, unit: 2'd1};
      in_e[2] = '{target: jmp_target, value: jmp_ori_pc, next_pc: jmp_next_pc, taken: 1'b1, unit: 2'd2};
      in_e[3] = '{target: br_target, value: 32'd0, next_pc: br_next_pc, taken: br_cmp_res, unit: 2'd3};
      for (int k = 0; k < 4; k++) pushv[k] = (in_e[k].target != INV);
      if (flush) begin
        for (int k = 0; k < 4; k++) mq[k].delete();
        m_rr = 0;
        m_wb.target = INV;
      end else begin
        found = 0; win = 0;
        for (int i = 0; i < 4; i++) begin
          u = (m_rr + i) % 4;
          if (!found && (mq[u].size() > 0 || pushv[u])) begin found = 1; win = u; end
        end
        for (int k = 0; k < 4; k++)
          if (pushv[k]) begin
            if (mq[k].size() == DEPTH && !(found && win == k)) m_ovf = 1'b1;
            else mq[k].push_back(in_e[k]);
          end
        if (found) begin
          m_wb = mq[win].pop_front();
          m_rr = (win + 1) % 4;
        end else begin
          m_wb.target = INV;
        end
      end
      for (int k = 0; k < 4; k++) m_stall[k] = (mq[k].size() >= DEPTH - 1);
    end
  end

  always @(negedge clk) begin
    chk("wb_target", 64'(wb_target), 64'(m_wb.target));
    chk("wb_value", 64'(wb_value), 64'(m_wb.value));
    chk("wb_next_pc", 64'(wb_next_pc), 64'(m_wb.next_pc));
    chk("wb_taken", 64'(wb_taken), 64'(m_wb.taken));
    chk("wb_unit", 64'(wb_unit), 64'(m_wb.unit));
    chk("stall", 64'(stall), 64'(m_stall));
    chk("overflow_err", 64'(overflow_err), 64'(m_ovf));
    if (wb_target != INV) begin
      dut_bc++;
      if (wb_unit == 2'd0) dut_alu_bc++;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    flush = 1'b0;
    alu_target = INV; fwd_target = INV; jmp_target = INV; br_target = INV;
  endtask

  task automatic do_flush();
    idle(); flush = 1'b1; tick(); flush = 1'b0;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int base;
    int seen;
    bit obey;
    #1 rst = 1'b0;
    #20 chk("reset_wb_target", 64'(wb_target), 64'(INV));
    chk("reset_stall", 64'(stall), 64'd0);
    chk("reset_ovf", 64'(overflow_err), 64'd0);
    @(negedge clk); rst = 1'b1;
    tick();

    // Single ALU result, one-cycle latency, then idle.
    repeat (4) tick();
    alu_target = 5'd3; alu_result = 32'h1234;
    tick();
    chk("t1_target", 64'(wb_target), 64'd3);
    chk("t1_value", 64'(wb_value), 64'h1234);
    chk("t1_unit", 64'(wb_unit), 64'd0);
    idle(); tick();
    chk("t1_idle", 64'(wb_target), 64'(INV));

    // All four units at once from RR=0.
    do_flush();
    alu_target = 5'd1; alu_result = 32'hA1;
    fwd_target = 5'd2; fwd_result = 32'hB2;
    jmp_target = 5'd3; jmp_ori_pc = 32'h100; jmp_next_pc = 32'h200;
    br_target  = 5'd4; br_next_pc = 32'h300; br_cmp_res = 1'b1;
    tick(); idle();
    chk("t2_tag1", 64'(wb_target), 64'd1);
    tick(); chk("t2_tag2", 64'(wb_target), 64'd2);
    tick(); chk("t2_tag3", 64'(wb_target), 64'd3);
    chk("t2_jmp_taken", 64'(wb_taken), 64'd1);
    chk("t2_jmp_value", 64'(wb_value), 64'h100);
    tick(); chk("t2_tag4", 64'(wb_target), 64'd4);
    chk("t2_br_taken", 64'(wb_taken), 64'd1);
    chk("t2_br_value", 64'(wb_value), 64'd0);
    chk("t2_br_npc", 64'(wb_next_pc), 64'h300);
    tick(); chk("t2_idle", 64'(wb_target), 64'(INV));

    // ALU and FWD stream while honouring stall.
    do_flush();
    seen = 0;
    for (int i = 0; i < 24; i++) begin
      alu_target = stall[0] ? INV : 5'(i % 30); alu_result = $urandom;
      fwd_target = stall[1] ? INV : 5'((i + 7) % 30); fwd_result = $urandom;
      tick();
      if (stall[0]) seen = 1;
    end
    idle(); repeat (8) tick();
    chk("t3_stall_seen", 64'(seen), 64'd1);
    chk("t3_no_ovf", 64'(overflow_err), 64'd0);

    // ALU ignores stall against three busy competitors: two of eight drop.
    do_flush();
    base = dut_alu_bc;
    for (int i = 0; i < 8; i++) begin
      alu_target = 5'(10 + i); alu_result = 32'(i);
      fwd_target = 5'(20 + i); jmp_target = 5'(1 + i); br_target = 5'(i);
      tick();
    end
    idle(); repeat (16) tick();
    chk("t4_ovf", 64'(overflow_err), 64'd1);
    chk("t4_alu_bcast", 64'(dut_alu_bc - base), 64'd6);

    // Buffered jump/branch entries vanish on flush; flush-cycle pushes are dropped.
    do_flush();
    for (int i = 0; i < 3; i++) begin
      jmp_target = 5'(20 + i); br_target = 5'(24 + i); tick();
    end
    idle(); flush = 1'b1; alu_target = 5'd9; tick(); idle();
    chk("t5_flush_target", 64'(wb_target), 64'(INV));
    chk("t5_flush_stall", 64'(stall), 64'd0);
    base = dut_bc;
    repeat (6) tick();
    chk("t5_no_old", 64'(dut_bc - base), 64'd0);

    // Randomized traffic with occasional flush.
    obey = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if (i % 50 == 0) obey = 1'($urandom_range(0, 1));
      flush = ($urandom_range(0, 99) < 3);
      alu_target = (($urandom_range(0, 9) < 6) && !(obey && stall[0])) ? 5'($urandom_range(0, 30)) : INV;
      fwd_target = (($urandom_range(0, 9) < 5) && !(obey && stall[1])) ? 5'($urandom_range(0, 30)) : INV;
      jmp_target = (($urandom_range(0, 9) < 4) && !(obey && stall[2])) ? 5'($urandom_range(0, 30)) : INV;
      br_target  = (($urandom_range(0, 9) < 4) && !(obey && stall[3])) ? 5'($urandom_range(0, 30)) : INV;
      alu_result = $urandom; fwd_result = $urandom; jmp_ori_pc = $urandom;
      jmp_next_pc = $urandom; br_next_pc = $urandom; br_cmp_res = 1'($urandom);
      tick();
    end

    // Asynchronous reset in the middle of a burst.
    alu_target = 5'd5; fwd_target = 5'd6; jmp_target = 5'd7; br_target = 5'd8;
    @(posedge clk); #3 rst = 1'b0;
    #1 chk("t6_async_target", 64'(wb_target), 64'(INV));
    chk("t6_async_ovf", 64'(overflow_err), 64'd0);
    chk("t6_async_stall", 64'(stall), 64'd0);
    idle();
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    base = dut_bc;
    repeat (6) tick();
    chk("t6_no_bcast", 64'(dut_bc - base), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
